gesture_cmd_scheduler: RTL and testbench

- Sits between the gesture detector FSMs (off, takeoff, move) and the drone command transmitter.
- Arbitrates simultaneous or overlapping gesture requests by priority, filters requests against the current flight mode, and issues one command at a time over a valid/ready handshake.
- Enforces a cooldown between commands and issues an automatic HOVER when hand tracking is lost.
- Pulses a clear back to the gesture FSMs after each accepted command.

---
 rtl/gesture_cmd_scheduler.sv | 237 +++++++++++++++++++++++
 tb/tb_gesture_cmd_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/gesture_cmd_scheduler.sv
// Gesture command scheduler: arbitrates gesture requests by priority and flight mode,
// issues one command at a time over valid/ready, then cools down and clears the gesture FSMs.
module gesture_cmd_scheduler #(
  parameter int COOLDOWN_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int CNT_W           = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       off_pulse,
  input  logic       takeoff_pulse,
  input  logic [3:0] move_req,
  input  logic       hands_valid,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_data,
  output logic       fsm_clear,
  output logic [1:0] mode,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_COOL = 2'd2
  } state_t;

  localparam logic [2:0] CMD_TAKEOFF = 3'd1;
  localparam logic [2:0] CMD_LAND    = 3'd2;
  localparam logic [2:0] CMD_HOVER   = 3'd3;
  localparam logic [2:0] CMD_UP      = 3'd4;
  localparam logic [2:0] CMD_DOWN    = 3'd5;
  localparam logic [2:0] CMD_LEFT    = 3'd6;
  localparam logic [2:0] CMD_RIGHT   = 3'd7;

  localparam logic [1:0] MODE_LANDED = 2'd0;
  localparam logic [1:0] MODE_FLYING = 2'd1;

  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_CYCLES);
  localparam logic [CNT_W-1:0] TO_MAX    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  state_t           state_r, state_n;
  logic             cmd_valid_r, cmd_valid_n;
  logic [2:0]       cmd_data_r, cmd_data_n;
  logic             fsm_clear_r, fsm_clear_n;
  logic [1:0]       mode_r, mode_n;
  logic             busy_r;
  logic             pend_off_r, pend_off_n;
  logic             pend_takeoff_r, pend_takeoff_n;
  logic             pend_hover_r, pend_hover_n;
  logic [CNT_W-1:0] cool_cnt_r, cool_cnt_n;
  logic [CNT_W-1:0] to_cnt_r, to_cnt_n;

  logic flying_s;
  logic req_off_s, req_takeoff_s, req_hover_s, req_move_s;
  logic take_off_s, take_takeoff_s, take_hover_s;

  // A same-cycle pulse counts as a request in IDLE, so issue latency is one cycle from the pulse.
  always_comb begin
    flying_s      = (mode_r == MODE_FLYING);
    req_off_s     = (pend_off_r | off_pulse) & flying_s;
    req_takeoff_s = (pend_takeoff_r | takeoff_pulse) & ~flying_s;
    req_hover_s   = pend_hover_r & flying_s;
    req_move_s    = (|move_req) & flying_s;
  end

  // Issue FSM: priority select in IDLE, handshake in SEND, countdown in COOL.
  always_comb begin
    state_n        = state_r;
    cmd_valid_n    = cmd_valid_r;
    cmd_data_n     = cmd_data_r;
    fsm_clear_n    = 1'b0;
    mode_n         = mode_r;
    cool_cnt_n     = cool_cnt_r;
    take_off_s     = 1'b0;
    take_takeoff_s = 1'b0;
    take_hover_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_off_s) begin
          cmd_data_n = CMD_LAND;
          take_off_s = 1'b1;
        end else if (req_takeoff_s) begin
          cmd_data_n     = CMD_TAKEOFF;
          take_takeoff_s = 1'b1;
        end else if (req_hover_s) begin
          cmd_data_n   = CMD_HOVER;
          take_hover_s = 1'b1;
        end else if (req_move_s) begin
          if (move_req[0]) begin
            cmd_data_n = CMD_UP;
          end else if (move_req[1]) begin
            cmd_data_n = CMD_DOWN;
          end else if (move_req[2]) begin
            cmd_data_n = CMD_LEFT;
          end else begin
            cmd_data_n = CMD_RIGHT;
          end
        end else begin
          cmd_data_n = cmd_data_r;
        end
        if (req_off_s | req_takeoff_s | req_hover_s | req_move_s) begin
          cmd_valid_n = 1'b1;
          state_n     = ST_SEND;
        end else begin
          cmd_valid_n = 1'b0;
          state_n     = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (cmd_ready) begin
          cmd_valid_n = 1'b0;
          fsm_clear_n = 1'b1;
          case (cmd_data_r)
            CMD_TAKEOFF: mode_n = MODE_FLYING;
            CMD_LAND:    mode_n = MODE_LANDED;
            default:     mode_n = mode_r;
          endcase
          if (COOLDOWN_CYCLES == 0) begin
            state_n    = ST_IDLE;
            cool_cnt_n = CNT_ZERO;
          end else begin
            state_n    = ST_COOL;
            cool_cnt_n = COOL_LOAD;
          end
        end else begin
          state_n = ST_SEND;
        end
      end
      ST_COOL: begin
        if (cool_cnt_r <= CNT_ONE) begin
          state_n    = ST_IDLE;
          cool_cnt_n = CNT_ZERO;
        end else begin
          state_n    = ST_COOL;
          cool_cnt_n = cool_cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_n     = ST_IDLE;
        cmd_valid_n = 1'b0;
        cool_cnt_n  = CNT_ZERO;
      end
    endcase
  end

  // Pending latches: set in any state, dropped when invalid for the current mode or consumed.
  always_comb begin
    if (off_pulse) begin
      pend_off_n = 1'b1;
    end else if (flying_s) begin
      pend_off_n = pend_off_r;
    end else begin
      pend_off_n = 1'b0;
    end
    if (take_off_s) begin
      pend_off_n = 1'b0;
    end else begin
      pend_off_n = pend_off_n;
    end

    if (takeoff_pulse) begin
      pend_takeoff_n = 1'b1;
    end else if (!flying_s) begin
      pend_takeoff_n = pend_takeoff_r;
    end else begin
      pend_takeoff_n = 1'b0;
    end
    if (take_takeoff_s) begin
      pend_takeoff_n = 1'b0;
    end else begin
      pend_takeoff_n = pend_takeoff_n;
    end
  end

  // Tracking-loss timeout: saturating count that raises a single HOVER request per loss episode.
  always_comb begin
    to_cnt_n     = to_cnt_r;
    pend_hover_n = pend_hover_r;
    if (!flying_s || hands_valid) begin
      to_cnt_n     = CNT_ZERO;
      pend_hover_n = 1'b0;
    end else if (to_cnt_r != TO_MAX) begin
      to_cnt_n = to_cnt_r + CNT_ONE;
      if ((to_cnt_r + CNT_ONE) == TO_MAX) begin
        pend_hover_n = 1'b1;
      end else begin
        pend_hover_n = pend_hover_r;
      end
    end else begin
      to_cnt_n = to_cnt_r;
    end
    if (take_hover_s) begin
      pend_hover_n = 1'b0;
    end else begin
      pend_hover_n = pend_hover_n;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      cmd_valid_r    <= 1'b0;
      cmd_data_r     <= 3'd0;
      fsm_clear_r    <= 1'b0;
      mode_r         <= MODE_LANDED;
      busy_r         <= 1'b0;
      pend_off_r     <= 1'b0;
      pend_takeoff_r <= 1'b0;
      pend_hover_r   <= 1'b0;
      cool_cnt_r     <= CNT_ZERO;
      to_cnt_r       <= CNT_ZERO;
    end else begin
      state_r        <= state_n;
      cmd_valid_r    <= cmd_valid_n;
      cmd_data_r     <= cmd_data_n;
      fsm_clear_r    <= fsm_clear_n;
      mode_r         <= mode_n;
      busy_r         <= (state_n != ST_IDLE);
      pend_off_r     <= pend_off_n;
      pend_takeoff_r <= pend_takeoff_n;
      pend_hover_r   <= pend_hover_n;
      cool_cnt_r     <= cool_cnt_n;
      to_cnt_r       <= to_cnt_n;
    end
  end

  assign cmd_valid = cmd_valid_r;
  assign cmd_data  = cmd_data_r;
  assign fsm_clear = fsm_clear_r;
  assign mode      = mode_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_gesture_cmd_scheduler.sv
// Bench for gesture_cmd_scheduler: directed scenarios plus random traffic,
// each cycle compared against a command-level reference model.
module tb_gesture_cmd_scheduler;

  localparam int COOL = 16;
  localparam int TO   = 255;

  logic       clock;
  logic       reset;
  logic       off_pulse;
  logic       takeoff_pulse;
  logic [3:0] move_req;
  logic       hands_valid;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd_data;
  logic       fsm_clear;
  logic [1:0] mode;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit m_valid, m_clear;
  int m_data, m_mode, m_cool;
  bit p_off, p_to, p_hv;
  int lost;

  // issue monitor
  bit prev_v;
  int issues, hovers, last_cmd;

  gesture_cmd_scheduler #(.COOLDOWN_CYCLES(COOL), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .off_pulse(off_pulse), .takeoff_pulse(takeoff_pulse),
    .move_req(move_req), .hands_valid(hands_valid), .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .fsm_clear(fsm_clear), .mode(mode), .busy(busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_clear = 0; m_data = 0; m_mode = 0; m_cool = 0;
    p_off = 0; p_to = 0; p_hv = 0; lost = 0; prev_v = 0;
  endtask

  // One clock of the command-level behaviour, driven by the inputs held during that cycle.
  task automatic model_step();
    bit fly, acc, idle, c_off, c_to, c_hv;
    int code;
    fly = (m_mode == 1);
    acc = m_valid && cmd_ready;
    idle = !m_valid && (m_cool == 0);
    c_off = 0; c_to = 0; c_hv = 0; code = -1;
    if (idle) begin
      if ((p_off || off_pulse) && fly) begin code = 2; c_off = 1; end
      else if ((p_to || takeoff_pulse) && !fly) begin code = 1; c_to = 1; end
      else if (p_hv && fly) begin code = 3; c_hv = 1; end
      else if (fly && move_req != 4'd0) begin
        for (int b = 3; b >= 0; b--) if (move_req[b]) code = 4 + b;
      end
    end
    m_clear = acc;
    if (acc) begin
      m_valid = 0;
      if (m_data == 1) m_mode = 1;
      else if (m_data == 2) m_mode = 0;
      m_cool = COOL;
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (code >= 0) begin
      m_valid = 1;
      m_data = code;
    end
    p_off = (off_pulse || (p_off && fly)) && !c_off;
    p_to  = (takeoff_pulse || (p_to && !fly)) && !c_to;
    if (!fly || hands_valid) begin
      lost = 0; p_hv = 0;
    end else if (lost < TO) begin
      lost++;
      if (lost == TO) p_hv = 1;
    end
    if (c_hv) p_hv = 0;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    model_step();
    check("valid", cmd_valid, m_valid);
    check("data", cmd_data, m_data);
    check("clear", fsm_clear, m_clear);
    check("mode", mode, m_mode);
    check("busy", busy, m_valid || (m_cool > 0));
    if (cmd_valid && !prev_v) begin
      issues++;
      last_cmd = cmd_data;
      if (cmd_data == 3'd3) hovers++;
    end
    prev_v = cmd_valid;
  endtask

  task automatic pulse_off();
    off_pulse = 1'b1; cyc(); off_pulse = 1'b0;
  endtask

  task automatic pulse_to();
    takeoff_pulse = 1'b1; cyc(); takeoff_pulse = 1'b0;
  endtask

  initial begin
    int n0, h0, bcnt;
    reset = 1'b0; off_pulse = 1'b0; takeoff_pulse = 1'b0; move_req = 4'd0;
    hands_valid = 1'b1; cmd_ready = 1'b0;
    issues = 0; hovers = 0; last_cmd = 0;
    model_reset();
    #2;
    check("rst_valid", cmd_valid, 1'b0);
    check("rst_data", cmd_data, 3'd0);
    check("rst_clear", fsm_clear, 1'b0);
    check("rst_mode", mode, 2'd0);
    check("rst_busy", busy, 1'b0);
    #20 reset = 1'b1;

    // takeoff accepted immediately, then 16 busy cycles of cooldown
    cmd_ready = 1'b1;
    pulse_to();
    check("t1_valid", cmd_valid, 1'b1);
    check("t1_data", cmd_data, 3'd1);
    cyc();
    check("t1_clear", fsm_clear, 1'b1);
    check("t1_mode", mode, 2'd1);
    bcnt = busy;
    for (int i = 0; i < 19; i++) begin cyc(); bcnt += busy; end
    check("t1_busy_len", bcnt, 16);

    // DOWN wins over LEFT, held stable under backpressure, issued once
    cmd_ready = 1'b0; move_req = 4'b0110;
    cyc();
    check("t2_data", cmd_data, 3'd5);
    repeat (10) cyc();
    check("t2_hold", cmd_valid, 1'b1);
    n0 = issues;
    cmd_ready = 1'b1;
    cyc();
    repeat (14) cyc();
    check("t2_norepeat", issues, n0);
    move_req = 4'd0;

    // off during COOL -> LAND on the first IDLE cycle; moves ignored when landed
    pulse_off();
    repeat (5) cyc();
    check("t3_land", last_cmd, 2);
    check("t3_issues", issues, n0 + 1);
    repeat (20) cyc();
    check("t3_mode", mode, 2'd0);
    n0 = issues; move_req = 4'b0001;
    repeat (30) cyc();
    check("t3_move_landed", issues, n0);
    move_req = 4'd0;

    // tracking loss -> exactly one HOVER per loss episode
    pulse_to();
    repeat (20) cyc();
    h0 = hovers; hands_valid = 1'b0;
    repeat (300) cyc();
    check("t4_hover1", hovers, h0 + 1);
    repeat (500) cyc();
    check("t4_no_second", hovers, h0 + 1);
    hands_valid = 1'b1; cyc(); hands_valid = 1'b0;
    repeat (300) cyc();
    check("t4_hover2", hovers, h0 + 2);
    hands_valid = 1'b1;
    repeat (20) cyc();

    // mode filtering of off/takeoff
    pulse_off();
    repeat (20) cyc();
    check("t5_landed", mode, 2'd0);
    n0 = issues;
    pulse_off();
    repeat (20) cyc();
    check("t5_off_landed", issues, n0);
    pulse_to();
    repeat (20) cyc();
    n0 = issues;
    off_pulse = 1'b1; takeoff_pulse = 1'b1; cyc();
    off_pulse = 1'b0; takeoff_pulse = 1'b0;
    repeat (40) cyc();
    check("t5_single", issues, n0 + 1);
    check("t5_land", last_cmd, 2);
    check("t5_mode", mode, 2'd0);

    // reset during SEND
    pulse_to();
    repeat (20) cyc();
    cmd_ready = 1'b0; move_req = 4'b0001;
    cyc();
    check("t6_send", cmd_valid, 1'b1);
    move_req = 4'd0;
    #2 reset = 1'b0;
    #1;
    check("t6_async_valid", cmd_valid, 1'b0);
    check("t6_async_mode", mode, 2'd0);
    check("t6_async_busy", busy, 1'b0);
    model_reset();
    n0 = issues;
    @(negedge clock) reset = 1'b1;
    cmd_ready = 1'b1;
    repeat (20) cyc();
    check("t6_no_retry", issues, n0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      off_pulse     = ($urandom_range(0, 39) == 0);
      takeoff_pulse = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) == 0) move_req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 149) == 0) hands_valid = ~hands_valid;
      cmd_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
